// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state encoding and the fault NOP word.
package fetch_pkg;

    localparam int DEF_XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        STALL
    } fetch_state_t;

    function automatic logic word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetches one instruction per request over a req/gnt/rvalid bus and
// hands it to decode through a registered valid/ready output stage.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter logic [XLEN-1:0] ERR_DATA = XLEN'(NOP_INSTR)
) (
    input  logic            clock,
    input  logic            resetActiveLow,
    input  logic [XLEN-1:0] programCounter,
    output logic            pcEnable,
    input  logic            redirectValid,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic            imemGnt,
    input  logic            imemRvalid,
    input  logic [XLEN-1:0] imemRdata,
    input  logic            imemErr,
    output logic            instrValid,
    input  logic            instrReady,
    output logic [XLEN-1:0] instrData,
    output logic [XLEN-1:0] instrPc,
    output logic            instrErr
);

    fetch_state_t    state;
    logic            discard;
    logic [XLEN-1:0] reqPc;
    logic            aligned;

    assign aligned  = word_aligned(programCounter[1:0]);
    assign imemAddr = programCounter;
    assign imemReq  = (state == REQ) && aligned && !redirectValid;
    assign pcEnable = redirectValid ||
                      ((state == REQ) && aligned && imemGnt);

    always_ff @(posedge clock or negedge resetActiveLow) begin
        if (!resetActiveLow) begin
            state      <= IDLE;
            discard    <= 1'b0;
            reqPc      <= '0;
            instrValid <= 1'b0;
            instrData  <= '0;
            instrPc    <= '0;
            instrErr   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= REQ;
                end
                REQ: begin
                    if (redirectValid) begin
                        state <= REQ;
                    end else if (!aligned) begin
                        instrValid <= 1'b1;
                        instrErr   <= 1'b1;
                        instrData  <= ERR_DATA;
                        instrPc    <= programCounter;
                        state      <= HOLD;
                    end else if (imemGnt) begin
                        reqPc <= programCounter;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // A redirect with the response still in flight must
                    // swallow that response when it eventually arrives.
                    if (redirectValid) begin
                        if (imemRvalid) begin
                            discard <= 1'b0;
                            state   <= REQ;
                        end else begin
                            discard <= 1'b1;
                        end
                    end else if (imemRvalid) begin
                        if (discard) begin
                            discard <= 1'b0;
                            state   <= REQ;
                        end else begin
                            instrValid <= 1'b1;
                            instrData  <= imemErr ? ERR_DATA : imemRdata;
                            instrPc    <= reqPc;
                            instrErr   <= imemErr;
                            state      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirectValid) begin
                        instrValid <= 1'b0;
                        state      <= REQ;
                    end else if (instrReady) begin
                        instrValid <= 1'b0;
                        state      <= instrErr ? STALL : REQ;
                    end
                end
                STALL: begin
                    if (redirectValid) begin
                        state <= REQ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: each task walks one scenario
// cycle by cycle, acting as PC register, memory and decode stage.
module tb_instr_fetch_unit;

    logic        clock;
    logic        resetActiveLow;
    logic [31:0] programCounter;
    logic        pcEnable;
    logic        redirectValid;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRvalid;
    logic [31:0] imemRdata;
    logic        imemErr;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instrData;
    logic [31:0] instrPc;
    logic        instrErr;

    int vectors = 0;
    int errors = 0;

    instr_fetch_unit dut (
        .clock(clock),
        .resetActiveLow(resetActiveLow),
        .programCounter(programCounter),
        .pcEnable(pcEnable),
        .redirectValid(redirectValid),
        .imemReq(imemReq),
        .imemAddr(imemAddr),
        .imemGnt(imemGnt),
        .imemRvalid(imemRvalid),
        .imemRdata(imemRdata),
        .imemErr(imemErr),
        .instrValid(instrValid),
        .instrReady(instrReady),
        .instrData(instrData),
        .instrPc(instrPc),
        .instrErr(instrErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic test_reset;
        resetActiveLow = 1'b0;
        programCounter = 32'h0;
        redirectValid = 1'b0;
        imemGnt = 1'b0;
        imemRvalid = 1'b0;
        imemRdata = 32'h0;
        imemErr = 1'b0;
        instrReady = 1'b0;
        #12;
        vectors++;
        if ({instrValid, instrErr, imemReq, pcEnable} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl: got %b expected 0000",
                     {instrValid, instrErr, imemReq, pcEnable});
        end
        vectors++;
        if (instrData !== 32'h0 || instrPc !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs: got data %h pc %h expected 0/0",
                     instrData, instrPc);
        end
        @(posedge clock);
        #1;
        resetActiveLow = 1'b1;
        settle();
        vectors++;
        if (imemReq !== 1'b0) begin
            errors++;
            $display("FAIL idle_noreq: got %b expected 0", imemReq);
        end
        step();
    endtask

    task automatic test_first_fetch;
        imemGnt = 1'b1;
        settle();
        vectors++;
        if (imemReq !== 1'b1 || imemAddr !== 32'h0 || pcEnable !== 1'b1) begin
            errors++;
            $display("FAIL first_req: got req %b addr %h en %b expected 1/0/1",
                     imemReq, imemAddr, pcEnable);
        end
        step();
        imemGnt = 1'b0;
        programCounter = 32'h4;
        imemRvalid = 1'b1;
        imemRdata = 32'h0050_0093;
        settle();
        vectors++;
        if (imemReq !== 1'b0 || pcEnable !== 1'b0 || instrValid !== 1'b0) begin
            errors++;
            $display("FAIL first_wait: got req %b en %b vld %b expected 0/0/0",
                     imemReq, pcEnable, instrValid);
        end
        step();
        imemRvalid = 1'b0;
        instrReady = 1'b1;
        settle();
        vectors++;
        if (instrValid !== 1'b1 || instrData !== 32'h0050_0093 ||
            instrPc !== 32'h0 || instrErr !== 1'b0) begin
            errors++;
            $display("FAIL first_instr: got vld %b data %h pc %h err %b expected 1/00500093/0/0",
                     instrValid, instrData, instrPc, instrErr);
        end
        step();
        instrReady = 1'b0;
        settle();
        vectors++;
        if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h4) begin
            errors++;
            $display("FAIL first_next: got vld %b req %b addr %h expected 0/1/4",
                     instrValid, imemReq, imemAddr);
        end
    endtask

    task automatic test_gnt_wait;
        programCounter = 32'h8;
        imemGnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            vectors++;
            if (imemReq !== 1'b1 || imemAddr !== 32'h8 || pcEnable !== 1'b0) begin
                errors++;
                $display("FAIL gnt_wait[%0d]: got req %b addr %h en %b expected 1/8/0",
                         i, imemReq, imemAddr, pcEnable);
            end
            step();
        end
        imemGnt = 1'b1;
        settle();
        vectors++;
        if (pcEnable !== 1'b1) begin
            errors++;
            $display("FAIL gnt_pulse: got %b expected 1", pcEnable);
        end
        step();
        imemGnt = 1'b0;
        programCounter = 32'hC;
        imemRvalid = 1'b1;
        imemRdata = 32'h00A0_0113;
        step();
        imemRvalid = 1'b0;
    endtask

    task automatic test_ready_hold;
        instrReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            vectors++;
            if (instrValid !== 1'b1 || instrData !== 32'h00A0_0113 ||
                instrPc !== 32'h8 || imemReq !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: got vld %b data %h pc %h req %b expected 1/00a00113/8/0",
                         i, instrValid, instrData, instrPc, imemReq);
            end
            step();
        end
        instrReady = 1'b1;
        settle();
        vectors++;
        if (imemReq !== 1'b0) begin
            errors++;
            $display("FAIL hold_accept_req: got %b expected 0", imemReq);
        end
        step();
        instrReady = 1'b0;
        settle();
        vectors++;
        if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'hC) begin
            errors++;
            $display("FAIL hold_next: got vld %b req %b addr %h expected 0/1/c",
                     instrValid, imemReq, imemAddr);
        end
    endtask

    task automatic test_redirect_wait;
        imemGnt = 1'b1;
        step();
        imemGnt = 1'b0;
        programCounter = 32'h10;
        redirectValid = 1'b1;
        settle();
        vectors++;
        if (pcEnable !== 1'b1 || imemReq !== 1'b0) begin
            errors++;
            $display("FAIL rdw_redirect: got en %b req %b expected 1/0",
                     pcEnable, imemReq);
        end
        step();
        redirectValid = 1'b0;
        programCounter = 32'h100;
        settle();
        vectors++;
        if (pcEnable !== 1'b0 || imemReq !== 1'b0) begin
            errors++;
            $display("FAIL rdw_waiting: got en %b req %b expected 0/0",
                     pcEnable, imemReq);
        end
        step();
        imemRvalid = 1'b1;
        imemRdata = 32'hDEAD_BEEF;
        step();
        imemRvalid = 1'b0;
        settle();
        vectors++;
        if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h100) begin
            errors++;
            $display("FAIL rdw_dropped: got vld %b req %b addr %h expected 0/1/100",
                     instrValid, imemReq, imemAddr);
        end
    endtask

    task automatic test_bus_error;
        redirectValid = 1'b1;
        settle();
        vectors++;
        if (imemReq !== 1'b0 || pcEnable !== 1'b1) begin
            errors++;
            $display("FAIL berr_redirect: got req %b en %b expected 0/1",
                     imemReq, pcEnable);
        end
        step();
        redirectValid = 1'b0;
        programCounter = 32'h20;
        imemGnt = 1'b1;
        step();
        imemGnt = 1'b0;
        programCounter = 32'h24;
        imemRvalid = 1'b1;
        imemErr = 1'b1;
        imemRdata = 32'hFFFF_FFFF;
        step();
        imemRvalid = 1'b0;
        imemErr = 1'b0;
        instrReady = 1'b1;
        settle();
        vectors++;
        if (instrValid !== 1'b1 || instrErr !== 1'b1 ||
            instrData !== 32'h13 || instrPc !== 32'h20) begin
            errors++;
            $display("FAIL berr_instr: got vld %b err %b data %h pc %h expected 1/1/13/20",
                     instrValid, instrErr, instrData, instrPc);
        end
        step();
        instrReady = 1'b0;
        imemGnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            vectors++;
            if (instrValid !== 1'b0 || imemReq !== 1'b0 || pcEnable !== 1'b0) begin
                errors++;
                $display("FAIL berr_stall[%0d]: got vld %b req %b en %b expected 0/0/0",
                         i, instrValid, imemReq, pcEnable);
            end
            step();
        end
        imemGnt = 1'b0;
        redirectValid = 1'b1;
        settle();
        vectors++;
        if (pcEnable !== 1'b1) begin
            errors++;
            $display("FAIL berr_resume_en: got %b expected 1", pcEnable);
        end
        step();
        redirectValid = 1'b0;
        programCounter = 32'h40;
        settle();
        vectors++;
        if (imemReq !== 1'b1 || imemAddr !== 32'h40) begin
            errors++;
            $display("FAIL berr_resume: got req %b addr %h expected 1/40",
                     imemReq, imemAddr);
        end
    endtask

    task automatic test_misaligned;
        redirectValid = 1'b1;
        step();
        redirectValid = 1'b0;
        programCounter = 32'h102;
        imemGnt = 1'b1;
        settle();
        vectors++;
        if (imemReq !== 1'b0 || pcEnable !== 1'b0) begin
            errors++;
            $display("FAIL mis_noreq: got req %b en %b expected 0/0",
                     imemReq, pcEnable);
        end
        step();
        imemGnt = 1'b0;
        settle();
        vectors++;
        if (instrValid !== 1'b1 || instrErr !== 1'b1 ||
            instrPc !== 32'h102 || instrData !== 32'h13) begin
            errors++;
            $display("FAIL mis_instr: got vld %b err %b pc %h data %h expected 1/1/102/13",
                     instrValid, instrErr, instrPc, instrData);
        end
        instrReady = 1'b1;
        step();
        instrReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            vectors++;
            if (instrValid !== 1'b0 || imemReq !== 1'b0) begin
                errors++;
                $display("FAIL mis_stall[%0d]: got vld %b req %b expected 0/0",
                         i, instrValid, imemReq);
            end
            step();
        end
        redirectValid = 1'b1;
        step();
        redirectValid = 1'b0;
        programCounter = 32'h200;
        settle();
        vectors++;
        if (imemReq !== 1'b1 || imemAddr !== 32'h200) begin
            errors++;
            $display("FAIL mis_resume: got req %b addr %h expected 1/200",
                     imemReq, imemAddr);
        end
    endtask

    task automatic test_redirect_hold;
        imemGnt = 1'b1;
        step();
        imemGnt = 1'b0;
        programCounter = 32'h204;
        imemRvalid = 1'b1;
        imemRdata = 32'h1234_5678;
        step();
        imemRvalid = 1'b0;
        instrReady = 1'b0;
        redirectValid = 1'b1;
        settle();
        vectors++;
        if (instrValid !== 1'b1 || instrPc !== 32'h200 || pcEnable !== 1'b1) begin
            errors++;
            $display("FAIL rdh_hold: got vld %b pc %h en %b expected 1/200/1",
                     instrValid, instrPc, pcEnable);
        end
        step();
        redirectValid = 1'b0;
        programCounter = 32'h300;
        settle();
        vectors++;
        if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h300) begin
            errors++;
            $display("FAIL rdh_next: got vld %b req %b addr %h expected 0/1/300",
                     instrValid, imemReq, imemAddr);
        end
    endtask

    task automatic test_reset_mid;
        imemGnt = 1'b1;
        step();
        imemGnt = 1'b0;
        programCounter = 32'h304;
        settle();
        resetActiveLow = 1'b0;
        settle();
        vectors++;
        if (imemReq !== 1'b0 || pcEnable !== 1'b0 || instrValid !== 1'b0 ||
            instrPc !== 32'h0 || instrData !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid: got req %b en %b vld %b pc %h data %h expected 0/0/0/0/0",
                     imemReq, pcEnable, instrValid, instrPc, instrData);
        end
        step();
        resetActiveLow = 1'b1;
        imemRvalid = 1'b1;
        imemRdata = 32'h0BAD_0BAD;
        step();
        settle();
        vectors++;
        if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h304) begin
            errors++;
            $display("FAIL rst_late_rvalid: got vld %b req %b addr %h expected 0/1/304",
                     instrValid, imemReq, imemAddr);
        end
        imemRvalid = 1'b0;
        step();
        settle();
        vectors++;
        if (instrValid !== 1'b0) begin
            errors++;
            $display("FAIL rst_late_quiet: got %b expected 0", instrValid);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_gnt_wait();
        test_ready_hold();
        test_redirect_wait();
        test_bus_error();
        test_misaligned();
        test_redirect_hold();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
